mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles waiting for mem_ack (only used with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  EX/MEM register holds a valid instruction.
REQ-005 RegWrite, MemToReg, MemRead, MemWrite  input  1 each  control bits from EX/MEM.
REQ-006 WriteReg  input  5  destination register; ALUResult  input  32  address/result; StoreData  input  32  store data.
REQ-007 stall  output  1  upstream SHALL hold EX/MEM contents while high.
REQ-008 mem_req, mem_we  output  1 each; mem_addr, mem_wdata  output  32 each  data-memory request.
REQ-009 mem_ack  input  1; mem_rdata  input  32  data-memory response.
REQ-010 wb_valid, RegWriteOut, MemToRegOut  output  1 each; WriteRegOut  output  5; ALUResultOut, MemDataOut  output  32  MEM/WB register feeding write-back.
REQ-011 mem_err  output  1  one-cycle timeout pulse.

Function
REQ-012 FSM states IDLE and WAIT; reset state IDLE.
REQ-013 IDLE, in_valid=1, MemRead=0, MemWrite=0: MEM/WB loads inputs next edge, wb_valid=1, MemDataOut=0; latency 1 cycle; stall=0.
REQ-014 IDLE, in_valid=1, MemRead|MemWrite=1: stall=1 combinationally; next edge latches request (addr=ALUResult, wdata=StoreData, we=MemWrite), controls, WriteReg into a hold register; mem_req=1; state WAIT; wb_valid=0.
REQ-015 MemRead and MemWrite both set: treated as write (mem_we=1).
REQ-016 WAIT: mem_req, mem_we, mem_addr, mem_wdata stable from hold register; stall=1; wb_valid=0 and RegWriteOut=0 each cycle without ack.
REQ-017 WAIT, mem_ack=1: next edge MEM/WB loads hold register, MemDataOut=mem_rdata, wb_valid=1; mem_req=0; state IDLE; stall=0 in the ack cycle so upstream advances.
REQ-018 mem_ack in IDLE ignored; mem_req never asserted in same cycle as acceptance (earliest ack one cycle after entering WAIT).
REQ-019 in_valid=0 in IDLE: bubble, wb_valid=0, RegWriteOut=0, other MEM/WB fields hold.
REQ-020 RegWriteOut=RegWrite&wb_valid always; no register write without wb_valid.
REQ-021 Memory address unaligned bits passed unmodified; alignment is not this block's concern.

Reset
REQ-022 rst low: immediately state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, RegWriteOut=0, MemToRegOut=0, WriteRegOut=0, ALUResultOut=0, MemDataOut=0, mem_err=0, timeout counter=0.
REQ-023 Reset during WAIT abandons outstanding access; a late mem_ack after release is ignored.

Configuration
REQ-024 Macro MEM_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without ack; on reaching TIMEOUT_CYCLES, next edge returns IDLE, mem_req=0, mem_err=1 one cycle, wb_valid=0 (instruction dropped), stall released.
REQ-025 MEM_TIMEOUT_EN undefined: no counter logic, mem_err tied 0, WAIT held indefinitely until mem_ack.

Structure
REQ-026 Shared package mem_stage_pkg: state enum (IDLE, WAIT), data width 32, register-address width 5, default TIMEOUT_CYCLES.
REQ-027 One sub-module mem_watchdog (counter plus expiry pulse), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-028 ALU op: in_valid=1, RegWrite=1, WriteReg=5, ALUResult=0x0000_00AA -> next cycle wb_valid=1, WriteRegOut=5, ALUResultOut=0xAA, stall=0 throughout.
REQ-029 Load: MemRead=1, MemToReg=1, ALUResult=0x100, mem_ack after 3 WAIT cycles with mem_rdata=0xDEAD_BEEF -> mem_addr=0x100, stall high 4 cycles, then wb_valid=1, MemDataOut=0xDEADBEEF.
REQ-030 Store: MemWrite=1, ALUResult=0x200, StoreData=0x1234 -> mem_we=1, mem_wdata=0x1234 held until ack; after ack wb_valid=1, RegWriteOut=0 (RegWrite=0).
REQ-031 Back-to-back load then ALU op, ack after 1 cycle -> ALU op reaches MEM/WB exactly one cycle after load; no instruction lost or duplicated.
REQ-032 rst low in WAIT, mem_ack pulsed 2 cycles after release -> mem_req=0 immediately, wb_valid stays 0, ack ignored.
REQ-033 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_err pulses once after 4 WAIT cycles, state IDLE, wb_valid=0, stall released.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int DATA_W          = 32;
    localparam int REG_W           = 5;
    localparam int TIMEOUT_DEFAULT = 255;

    // IDLE: accepting from EX/MEM; WAIT: data-memory access outstanding.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting on the data memory and flags expiry.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 255   // must be >= 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,      // access accepted, WAIT about to start
    input  logic count_en,   // WAIT cycle without ack
    output logic expire,     // this WAIT cycle is the last one allowed
    output logic err         // one-cycle pulse after expiry
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Expiry is seen in the cycle that would bring the count to the limit.
    assign expire = count_en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait-cycle counter, cleared whenever a new access is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cnt <= '0;
        else if (clear)    cnt <= '0;
        else if (count_en) cnt <= cnt + CNT_W'(1);
    end

    // Error pulse lines up with the return to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else      err <= expire;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream while
// waiting, and loads the MEM/WB register.
// Optional access timeout: define MEM_TIMEOUT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] StoreData,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              RegWriteOut,
    output logic              MemToRegOut,
    output logic [REG_W-1:0]  WriteRegOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [DATA_W-1:0] MemDataOut,
    output logic              mem_err
);

    state_t state, state_nx;

    // Hold register: the outstanding access plus what write-back needs later.
    logic              h_we, h_rw, h_m2r;
    logic [REG_W-1:0]  h_wreg;
    logic [DATA_W-1:0] h_addr, h_wdata;
    logic              wb_rw;

    logic is_mem, accept, pass, done, expire;

    assign is_mem = MemRead | MemWrite;
    assign accept = (state == IDLE) && in_valid && is_mem;
    assign pass   = (state == IDLE) && in_valid && !is_mem;
    assign done   = (state == WAIT) && mem_ack;

    // Stall on acceptance and every waiting cycle; release in the ack (or
    // expiry) cycle so upstream advances on the same edge we leave WAIT.
    assign stall = accept || ((state == WAIT) && !mem_ack && !expire);

    assign mem_req     = (state == WAIT);
    assign mem_we      = (state == WAIT) && h_we;
    assign mem_addr    = h_addr;
    assign mem_wdata   = h_wdata;
    assign RegWriteOut = wb_rw & wb_valid;

`ifdef MEM_TIMEOUT_EN
    mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .count_en ((state == WAIT) && !mem_ack),
        .expire   (expire),
        .err      (mem_err)
    );
`else
    // Without a watchdog an access waits for mem_ack indefinitely.
    assign expire  = 1'b0;
    assign mem_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state: ack wins over a same-cycle expiry.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = WAIT;
            WAIT: if (mem_ack || expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture the access on acceptance; a write wins if both bits are set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_we    <= 1'b0;
            h_rw    <= 1'b0;
            h_m2r   <= 1'b0;
            h_wreg  <= '0;
            h_addr  <= '0;
            h_wdata <= '0;
        end else if (accept) begin
            h_we    <= MemWrite;
            h_rw    <= RegWrite;
            h_m2r   <= MemToReg;
            h_wreg  <= WriteReg;
            h_addr  <= ALUResult;
            h_wdata <= StoreData;
        end
    end

    // MEM/WB register: non-memory ops pass straight through, memory ops load
    // from the hold register on ack; bubbles keep the data fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            wb_rw        <= 1'b0;
            MemToRegOut  <= 1'b0;
            WriteRegOut  <= '0;
            ALUResultOut <= '0;
            MemDataOut   <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (pass) begin
                wb_valid     <= 1'b1;
                wb_rw        <= RegWrite;
                MemToRegOut  <= MemToReg;
                WriteRegOut  <= WriteReg;
                ALUResultOut <= ALUResult;
                MemDataOut   <= '0;
            end else if (done) begin
                wb_valid     <= 1'b1;
                wb_rw        <= h_rw;
                MemToRegOut  <= h_m2r;
                WriteRegOut  <= h_wreg;
                ALUResultOut <= h_addr;
                MemDataOut   <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of single-cycle ops, hand sequences for memory
// accesses, reset during WAIT and (with MEM_TIMEOUT_EN) the timeout path.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, RegWrite = 1'b0, MemToReg = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] ALUResult = '0, StoreData = '0;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, RegWriteOut, MemToRegOut;
    logic [4:0]  WriteRegOut;
    logic [31:0] ALUResultOut, MemDataOut;
    logic        mem_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] md;
        logic        rw;
        logic        m2r;
    } wb_t;

    wb_t sb[$];
    wb_t got;

    typedef struct {
        logic        v, rw, m2r;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic        ewb;
        logic [4:0]  ewr;
        logic [31:0] ealu;
        logic        erw;
    } vec_t;

    vec_t vecs[6];

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .WriteReg(WriteReg), .ALUResult(ALUResult), .StoreData(StoreData),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .RegWriteOut(RegWriteOut),
        .MemToRegOut(MemToRegOut), .WriteRegOut(WriteRegOut),
        .ALUResultOut(ALUResultOut), .MemDataOut(MemDataOut), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every wb_valid must match the oldest expected record.
    always @(negedge clk) begin
        if (rst) begin
            if (wb_valid) begin
                if (sb.size() == 0) chk("wb_unexpected", wb_valid, 1'b0);
                else begin
                    got = sb.pop_front();
                    chk("sb_wreg", WriteRegOut,  got.wr);
                    chk("sb_alu",  ALUResultOut, got.alu);
                    chk("sb_mdata", MemDataOut,  got.md);
                    chk("sb_rw",   RegWriteOut,  got.rw);
                    chk("sb_m2r",  MemToRegOut,  got.m2r);
                end
            end else begin
                chk("rw_gated", RegWriteOut, 1'b0);
            end
        end
    end

    // One memory access: accept, `waits` cycles without ack, then ack.
    // Returns #1 after the ack edge with inputs idle.
    task automatic mem_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                          input logic [4:0] wreg, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rdata, input int waits);
        int  stalls;
        wb_t e;
        stalls = 0;
        in_valid = 1'b1; MemRead = rd; MemWrite = wr; RegWrite = rw; MemToReg = m2r;
        WriteReg = wreg; ALUResult = addr; StoreData = sd;
        e = '{wreg, addr, rdata, rw, m2r};
        sb.push_back(e);
        #3;
        chk("accept_stall", stall, 1'b1);
        chk("accept_no_req", mem_req, 1'b0);
        if (stall) stalls++;
        for (int i = 0; i < waits; i++) begin
            tick(); #3;
            chk("wait_req",   mem_req,   1'b1);
            chk("wait_we",    mem_we,    wr);
            chk("wait_addr",  mem_addr,  addr);
            chk("wait_wdata", mem_wdata, sd);
            chk("wait_wbv",   wb_valid,  1'b0);
            if (stall) stalls++;
        end
        tick();
        mem_ack = 1'b1; mem_rdata = rdata;
        #3;
        chk("ack_stall", stall, 1'b0);
        chk("ack_req",   mem_req, 1'b1);
        chk("ack_addr",  mem_addr, addr);
        chk("stall_cycles", stalls, waits + 1);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //           v rw m2r wr  alu            ewb ewr ealu           erw
        vecs[0] = '{1, 1, 0,  5,  32'h0000_00AA, 1,  5,  32'h0000_00AA, 1};
        vecs[1] = '{1, 0, 1,  31, 32'hFFFF_FFFF, 1,  31, 32'hFFFF_FFFF, 0};
        vecs[2] = '{0, 1, 0,  7,  32'h0000_0055, 0,  31, 32'hFFFF_FFFF, 0};
        vecs[3] = '{1, 1, 1,  0,  32'h0000_0003, 1,  0,  32'h0000_0003, 1};
        vecs[4] = '{0, 1, 1,  9,  32'h0000_0099, 0,  0,  32'h0000_0003, 0};
        vecs[5] = '{1, 1, 0,  12, 32'h8000_0001, 1,  12, 32'h8000_0001, 1};

        // Reset values while rst is held low.
        #2;
        chk("rst_mem_req",  mem_req, 1'b0);
        chk("rst_mem_we",   mem_we, 1'b0);
        chk("rst_addr",     mem_addr, 32'h0);
        chk("rst_wdata",    mem_wdata, 32'h0);
        chk("rst_wbv",      wb_valid, 1'b0);
        chk("rst_rw",       RegWriteOut, 1'b0);
        chk("rst_m2r",      MemToRegOut, 1'b0);
        chk("rst_wreg",     WriteRegOut, 5'd0);
        chk("rst_alu",      ALUResultOut, 32'h0);
        chk("rst_mdata",    MemDataOut, 32'h0);
        chk("rst_err",      mem_err, 1'b0);
        chk("rst_stall",    stall, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Single-cycle ops and bubbles.
        for (int i = 0; i < 6; i++) begin
            in_valid = vecs[i].v; RegWrite = vecs[i].rw; MemToReg = vecs[i].m2r;
            WriteReg = vecs[i].wr; ALUResult = vecs[i].alu; StoreData = 32'h5A5A_0000 + i;
            MemRead = 1'b0; MemWrite = 1'b0;
            if (vecs[i].v) sb.push_back('{vecs[i].wr, vecs[i].alu, 32'h0, vecs[i].rw, vecs[i].m2r});
            #3;
            chk("vec_stall", stall, 1'b0);
            chk("vec_req",   mem_req, 1'b0);
            tick();
            chk("vec_wbv",  wb_valid,     vecs[i].ewb);
            chk("vec_wreg", WriteRegOut,  vecs[i].ewr);
            chk("vec_alu",  ALUResultOut, vecs[i].ealu);
            chk("vec_rw",   RegWriteOut,  vecs[i].erw);
        end
        in_valid = 1'b0;
        tick();

        // Load, ack after 3 waiting cycles.
        mem_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
        #3;
        chk("load_wbv",   wb_valid, 1'b1);
        chk("load_mdata", MemDataOut, 32'hDEAD_BEEF);
        chk("load_req_off", mem_req, 1'b0);
        tick();

        // Store, RegWrite=0.
        mem_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0200, 32'h0000_1234, 32'h0, 2);
        #3;
        chk("store_wbv", wb_valid, 1'b1);
        chk("store_rw",  RegWriteOut, 1'b0);
        tick();

        // Read and write both set behaves as a write; unaligned address kept.
        mem_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0303, 32'h0000_CAFE, 32'h0000_0077, 1);
        tick();

        // Load then ALU op back to back.
        mem_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0040, 32'h0, 32'h1111_2222, 1);
        in_valid = 1'b1; RegWrite = 1'b1; MemToReg = 1'b0; WriteReg = 5'd7; ALUResult = 32'h0000_0777;
        sb.push_back('{5'd7, 32'h0000_0777, 32'h0, 1'b1, 1'b0});
        #3;
        chk("b2b_load_wreg", WriteRegOut, 5'd6);
        chk("b2b_alu_stall", stall, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("b2b_alu_wbv",  wb_valid, 1'b1);
        chk("b2b_alu_wreg", WriteRegOut, 5'd7);
        tick();
        chk("b2b_no_dup", wb_valid, 1'b0);

        // Reset during WAIT, then a late ack.
        in_valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; WriteReg = 5'd8; ALUResult = 32'h0000_0400;
        tick(); #3;
        chk("rstw_req_before", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("rstw_req",  mem_req, 1'b0);
        chk("rstw_addr", mem_addr, 32'h0);
        chk("rstw_wbv",  wb_valid, 1'b0);
        in_valid = 1'b0; MemRead = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
        #3;
        chk("late_ack_stall", stall, 1'b0);
        tick();
        mem_ack = 1'b0;
        #3;
        chk("late_ack_wbv", wb_valid, 1'b0);
        chk("late_ack_req", mem_req, 1'b0);
        tick(); #3;
        chk("late_ack_wbv2", wb_valid, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No ack: expiry after 4 waiting cycles, instruction dropped.
        in_valid = 1'b1; MemRead = 1'b1; WriteReg = 5'd2; ALUResult = 32'h0000_0500;
        tick();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("to_stall", stall, 1'b1);
            chk("to_err_low", mem_err, 1'b0);
            tick();
        end
        in_valid = 1'b0; MemRead = 1'b0;
        tick(); #3;
        chk("to_err",   mem_err, 1'b1);
        chk("to_req",   mem_req, 1'b0);
        chk("to_wbv",   wb_valid, 1'b0);
        chk("to_stall_rel", stall, 1'b0);
        tick(); #3;
        chk("to_err_once", mem_err, 1'b0);
`else
        chk("err_tied", mem_err, 1'b0);
`endif

        tick(); tick();
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
